fifo_rd_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_rd_packer.sv | 126 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared state encoding and sizing helpers for the FIFO read-side packer.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Lane counter must hold LANES itself, hence one bit beyond the lane index.
  function automatic int lane_idx_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic int timeout_cnt_w(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the async FIFO read port and packs them little-endian into
// LANES-wide words on a valid/ready output, with flush and idle-timeout emit.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_dout,
  output logic                   fifo_rd_en,
  input  logic                   flush,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int LANE_IDX_W = lane_idx_w(LANES);
  localparam int TW         = timeout_cnt_w(TIMEOUT);
  localparam logic [LANE_IDX_W-1:0] FULL    = LANE_IDX_W'(LANES);
  localparam logic [TW-1:0]         TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]         TO_LAST = TW'(TIMEOUT - 1);
  localparam bit                    TO_EN   = (TIMEOUT != 0);

  state_t                  state, state_nx;
  logic [LANE_IDX_W-1:0]   acc_cnt;
  logic                    rd_pending;
  logic                    flush_pend;
  logic [TW-1:0]           idle_cnt;
  logic [WIDTH*LANES-1:0]  acc;

  logic                    capture;
  logic                    load;
  logic                    flush_clr;
  logic                    idle_tick;
  logic                    timeout_hit;
  logic [LANE_IDX_W:0]     inflight;

  function automatic logic [LANES-1:0] keep_mask(input logic [LANE_IDX_W-1:0] n);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[i] = (LANE_IDX_W'(i) < n);
    return m;
  endfunction

  // Counting the in-flight byte keeps the accumulator from ever being overrun.
  assign inflight    = {1'b0, acc_cnt} + {{LANE_IDX_W{1'b0}}, rd_pending};
  assign fifo_rd_en  = rst_n && !fifo_empty && !flush_pend && (state != ST_DRAIN) &&
                       (inflight < (LANE_IDX_W + 1)'(LANES));
  assign capture     = rd_pending;
  assign load        = (state == ST_DRAIN) && (!out_valid || out_ready);
  assign idle_tick   = (acc_cnt != '0) && !rd_pending && !flush_pend;
  assign timeout_hit = TO_EN && idle_tick && (idle_cnt == TO_LAST);

  always_comb begin
    state_nx  = state;
    flush_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (capture)         state_nx  = ST_FILL;
        else if (flush_pend) flush_clr = 1'b1;
      end
      ST_FILL: begin
        // A flush waits for the in-flight byte so it lands in this word.
        if ((acc_cnt == FULL) || (flush_pend && !rd_pending)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (load) begin
          state_nx  = ST_IDLE;
          flush_clr = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (load)         acc_cnt <= '0;
      else if (capture) acc_cnt <= acc_cnt + 1'b1;
      if (flush_clr)                  flush_pend <= 1'b0;
      else if (flush || timeout_hit)  flush_pend <= 1'b1;
      if (capture || load)                        idle_cnt <= '0;
      else if (idle_tick && (idle_cnt != TO_MAX)) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      acc       <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else begin
      // Clearing on load keeps the unused lanes of a partial word at zero.
      if (load) begin
        acc <= '0;
      end else if (capture) begin
        for (int i = 0; i < LANES; i++)
          if (acc_cnt == LANE_IDX_W'(i)) acc[i*WIDTH +: WIDTH] <= fifo_dout;
      end
      if (load) begin
        out_data  <= acc;
        out_keep  <= keep_mask(acc_cnt);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: queue-based FIFO stand-in, word-level
// scoreboard built from the pushed byte stream, and literal spot checks.
module tb_fifo_rd_packer;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [W*L-1:0] d;
    logic [L-1:0]   k;
  } word_t;

  logic           clk = 1'b0;
  logic           rst_n, fifo_empty, flush, out_ready, fifo_rd_en, out_valid;
  logic [W-1:0]   fifo_dout;
  logic [W*L-1:0] out_data;
  logic [L-1:0]   out_keep;

  logic           z_empty, z_flush, z_ready, z_rd_en, z_valid;
  logic [W-1:0]   z_dout;
  logic [W*L-1:0] z_data;
  logic [L-1:0]   z_keep;

  always #5 clk = ~clk;

  fifo_rd_packer #(.WIDTH(W), .LANES(L), .TIMEOUT(TO)) dut (
    .rd_clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  fifo_rd_packer #(.WIDTH(W), .LANES(L), .TIMEOUT(0)) dut_nt (
    .rd_clk(clk), .rst_n(rst_n), .fifo_empty(z_empty), .fifo_dout(z_dout),
    .fifo_rd_en(z_rd_en), .flush(z_flush), .out_data(z_data), .out_keep(z_keep),
    .out_valid(z_valid), .out_ready(z_ready)
  );

  logic [W-1:0] src_q[$];
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] z_q[$];
  word_t        exp_q[$];

  int n_pass = 0, n_total = 0;
  int pops = 0, words = 0, cyc = 0, last_rd_cyc = 0;
  int popped = 0, consumed = 0, z_words = 0;
  logic gap_mode = 1'b0, gap_phase = 1'b0, prev_stall = 1'b0;
  word_t prev_w;
  logic [W*L-1:0] last_d = '0, z_last_d = '0;
  logic [L-1:0]   last_k = '0, z_last_k = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_byte(input logic [W-1:0] b);
    src_q.push_back(b);
    mdl_q.push_back(b);
  endtask

  // Expected word: next n bytes of the stream, first byte in the low lane.
  task automatic exp_chunk(input int n);
    word_t w;
    w.d = '0;
    w.k = '0;
    for (int i = 0; i < n; i++) begin
      w.d   = w.d | ((W*L)'(mdl_q.pop_front()) << (W * i));
      w.k[i] = 1'b1;
    end
    exp_q.push_back(w);
  endtask

  task automatic step();
    word_t w;
    logic  rd_s, z_rd_s;
    fifo_empty = (src_q.size() == 0) || (gap_mode && gap_phase);
    z_empty    = (z_q.size() == 0);
    #1;
    rd_s   = fifo_rd_en;
    z_rd_s = z_rd_en;
    if (!rst_n) begin
      popped   = 0;
      consumed = 0;
    end else begin
      if (fifo_empty) check("rd_en_while_empty", 64'(fifo_rd_en), 64'(0));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(prev_w.d));
        check("hold_keep", 64'(out_keep), 64'(prev_w.k));
      end
      check("occupancy_bound", 64'(popped - consumed <= 2 * L), 64'(1));
      if (out_valid && out_ready) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(w.d));
          check("word_keep", 64'(out_keep), 64'(w.k));
        end
        words++;
        consumed += $countones(out_keep);
        last_d = out_data;
        last_k = out_keep;
      end
      if (rd_s) begin
        pops++;
        popped++;
        last_rd_cyc = cyc;
      end
      if (z_valid && z_ready) begin
        z_words++;
        z_last_d = z_data;
        z_last_k = z_keep;
      end
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_w     = {out_data, out_keep};
    @(posedge clk);
    #1;
    if (rst_n && rd_s && src_q.size() > 0) fifo_dout = src_q.pop_front();
    if (rst_n && z_rd_s && z_q.size() > 0) z_dout = z_q.pop_front();
    gap_phase = ~gap_phase;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_empty(input int max, input string name);
    for (int i = 0; i < max && exp_q.size() > 0; i++) step();
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int p0, w0, lat;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; fifo_dout = '0; fifo_empty = 1'b1;
    z_flush = 1'b0; z_ready = 1'b1; z_dout = '0; z_empty = 1'b1;
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_data", 64'(out_data), 64'(0));
    check("reset_keep", 64'(out_keep), 64'(0));
    check("reset_rd_en", 64'(fifo_rd_en), 64'(0));

    // Basic pack
    p0 = pops; w0 = words;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    exp_chunk(4);
    for (int i = 0; i < 30 && !out_valid; i++) step();
    // pop edge, capture edge, then DRAIN and load
    check("basic_latency", 64'(cyc - last_rd_cyc), 64'(4));
    run_until_empty(10, "basic_done");
    run(4);
    check("basic_pops", 64'(pops - p0), 64'(4));
    check("basic_words", 64'(words - w0), 64'(1));
    check("basic_data", 64'(last_d), 64'(32'h44332211));
    check("basic_keep", 64'(last_k), 64'(4'hF));

    // Backpressure
    out_ready = 1'b0;
    p0 = pops; w0 = words;
    for (int i = 1; i <= 12; i++) push_byte(W'(i));
    exp_chunk(4); exp_chunk(4); exp_chunk(4);
    run(25);
    check("bp_pops", 64'(pops - p0), 64'(8));
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_hold_data", 64'(out_data), 64'(32'h04030201));
    out_ready = 1'b1;
    run_until_empty(40, "bp_done");
    check("bp_words", 64'(words - w0), 64'(3));
    check("bp_last", 64'(last_d), 64'(32'h0C0B0A09));
    run(4);

    // Explicit flush of a partial word, then a flush with nothing buffered
    w0 = words;
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    exp_chunk(3);
    run(8);
    flush = 1'b1; step(); flush = 1'b0;
    run_until_empty(20, "flush_done");
    check("flush_data", 64'(last_d), 64'(32'h00A3A2A1));
    check("flush_keep", 64'(last_k), 64'(4'b0111));
    w0 = words;
    run(3);
    flush = 1'b1; step(); flush = 1'b0;
    run(30);
    check("flush_empty_no_word", 64'(words - w0), 64'(0));

    // Idle timeout (main instance) and disabled timeout (second instance)
    w0 = words;
    push_byte(8'h5A); push_byte(8'hC3);
    z_q.push_back(8'h5A); z_q.push_back(8'hC3);
    exp_chunk(2);
    for (int i = 0; i < 80 && !out_valid; i++) step();
    // pop edge, capture edge, TO idle edges, then DRAIN and load
    check("timeout_latency", 64'(cyc - last_rd_cyc), 64'(1 + 1 + TO + 2));
    run_until_empty(5, "timeout_done");
    run(30);
    check("timeout_words", 64'(words - w0), 64'(1));
    check("timeout_data", 64'(last_d), 64'(32'h0000C35A));
    check("timeout_keep", 64'(last_k), 64'(4'b0011));
    check("no_timeout_words", 64'(z_words), 64'(0));
    z_flush = 1'b1; step(); z_flush = 1'b0;
    run(8);
    check("no_timeout_flush_words", 64'(z_words), 64'(1));
    check("no_timeout_flush_data", 64'(z_last_d), 64'(32'h0000C35A));
    check("no_timeout_flush_keep", 64'(z_last_k), 64'(4'b0011));

    // Reset with a held word and a partial accumulator
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) src_q.push_back(W'(8'h20 + i));
    run(14);
    check("pre_reset_pops", 64'(pops - p0), 64'(6));
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midreset_valid", 64'(out_valid), 64'(0));
    check("midreset_keep", 64'(out_keep), 64'(0));
    check("midreset_rd_en", 64'(fifo_rd_en), 64'(0));
    out_ready = 1'b1;
    push_byte(8'h10); push_byte(8'h11); push_byte(8'h12); push_byte(8'h13);
    exp_chunk(4);
    run_until_empty(30, "post_reset_done");
    check("post_reset_data", 64'(last_d), 64'(32'h13121110));
    check("post_reset_keep", 64'(last_k), 64'(4'hF));
    run(4);

    // Bursty empty flag
    gap_mode = 1'b1;
    p0 = pops; w0 = words;
    for (int i = 0; i < 20; i++) push_byte(W'(8'h40 + i));
    for (int i = 0; i < 5; i++) exp_chunk(4);
    run_until_empty(200, "bursty_done");
    gap_mode = 1'b0;
    check("bursty_pops", 64'(pops - p0), 64'(20));
    check("bursty_words", 64'(words - w0), 64'(5));
    check("bursty_last", 64'(last_d), 64'(32'h53525150));
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
